// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings and constants for the pipelined core memory stage
package pipe_pkg;

    localparam int PKG_DW = 8;
    localparam int PKG_AW = 8;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_IO  = 2'b10;
    localparam logic [1:0] MTR_FWD = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    function automatic logic need_access(input logic mem_write, input logic is_call,
                                         input logic [1:0] mem_to_reg);
        return mem_write | is_call | (mem_to_reg == MTR_MEM);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - access timeout counter with clear, enable and expire flag
module mem_timeout_ctr #(
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = (r_cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory stage: EX/MEM to MEM/WB with req/ack data-memory port and IO register
module mem_stage_ctrl
    import pipe_pkg::*;
#(
    parameter int DW      = PKG_DW,
    parameter int AW      = PKG_AW,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pc_plus1,
    input  logic [DW-1:0] Rd2,
    input  logic          IO_Write,
    input  logic [1:0]    RegDistidx,
    input  logic [AW-1:0] ALU_res,
    input  logic [DW-1:0] FW_value,
    input  logic          MemWrite,
    input  logic [1:0]    MemToReg,
    input  logic          RegWrite,
    input  logic          isCall,
    input  logic [DW-1:0] io_in,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    output logic          mem_stall,
    output logic          mem_err,
    output logic [DW-1:0] io_out,
    output logic [DW-1:0] wb_data,
    output logic [1:0]    wb_idx,
    output logic          wb_regwrite
);

    mem_state_e    r_state;
    mem_state_e    w_state_nxt;
    logic          w_need_acc;
    logic          w_expire;
    logic [DW-1:0] w_retire_data;

    logic [1:0]    r_lat_idx;
    logic          r_lat_rw;
    logic          r_lat_iow;
    logic [DW-1:0] r_lat_fw;
    logic          r_lat_load;

    assign w_need_acc = need_access(MemWrite, isCall, MemToReg);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (r_state == ST_IDLE),
        .i_en     ((r_state == ST_BUSY) && !dmem_ack),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_stall   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                mem_stall = w_need_acc;
                if (w_need_acc) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                mem_stall = ~dmem_ack;
                if (dmem_ack || w_expire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_retire_data = DW'(ALU_res);
        case (MemToReg)
            MTR_IO:  w_retire_data = io_in;
            MTR_FWD: w_retire_data = FW_value;
            default: w_retire_data = DW'(ALU_res);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            mem_err     <= 1'b0;
            io_out      <= '0;
            wb_data     <= '0;
            wb_idx      <= '0;
            wb_regwrite <= 1'b0;
            r_lat_idx   <= '0;
            r_lat_rw    <= 1'b0;
            r_lat_iow   <= 1'b0;
            r_lat_fw    <= '0;
            r_lat_load  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_need_acc) begin
                        dmem_req    <= 1'b1;
                        dmem_addr   <= ALU_res;
                        wb_regwrite <= 1'b0;
                        r_lat_idx   <= RegDistidx;
                        r_lat_rw    <= RegWrite;
                        r_lat_iow   <= IO_Write;
                        r_lat_fw    <= FW_value;
                        // A call that also sets MemWrite still issues only the return-address push.
                        if (isCall) begin
                            dmem_we    <= 1'b1;
                            dmem_wdata <= pc_plus1;
                            r_lat_load <= 1'b0;
                        end else if (MemWrite) begin
                            dmem_we    <= 1'b1;
                            dmem_wdata <= Rd2;
                            r_lat_load <= 1'b0;
                        end else begin
                            dmem_we    <= 1'b0;
                            r_lat_load <= 1'b1;
                        end
                    end else begin
                        wb_idx      <= RegDistidx;
                        wb_regwrite <= RegWrite;
                        wb_data     <= w_retire_data;
                        if (IO_Write) begin
                            io_out <= FW_value;
                        end
                    end
                end
                ST_BUSY: begin
                    if (dmem_ack) begin
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                        wb_idx      <= r_lat_idx;
                        wb_regwrite <= r_lat_rw;
                        wb_data     <= r_lat_load ? dmem_rdata : '0;
                        if (r_lat_iow) begin
                            io_out <= r_lat_fw;
                        end
                    end else if (w_expire) begin
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                        mem_err     <= 1'b1;
                        wb_idx      <= r_lat_idx;
                        wb_regwrite <= 1'b0;
                    end else begin
                        wb_regwrite <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pc_plus1, Rd2, FW_value, io_in, dmem_rdata, ALU_res;
    logic       IO_Write, MemWrite, RegWrite, isCall, dmem_ack;
    logic [1:0] RegDistidx, MemToReg;
    logic       dmem_req, dmem_we, mem_stall, mem_err, wb_regwrite;
    logic [7:0] dmem_addr, dmem_wdata, io_out, wb_data;
    logic [1:0] wb_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl dut (
        .clk(clk), .rst(rst), .pc_plus1(pc_plus1), .Rd2(Rd2), .IO_Write(IO_Write),
        .RegDistidx(RegDistidx), .ALU_res(ALU_res), .FW_value(FW_value),
        .MemWrite(MemWrite), .MemToReg(MemToReg), .RegWrite(RegWrite), .isCall(isCall),
        .io_in(io_in), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .mem_stall(mem_stall), .mem_err(mem_err),
        .io_out(io_out), .wb_data(wb_data), .wb_idx(wb_idx), .wb_regwrite(wb_regwrite)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        pc_plus1 = 8'h00; Rd2 = 8'h00; FW_value = 8'h00; ALU_res = 8'h00;
        IO_Write = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0; isCall = 1'b0;
        RegDistidx = 2'd0; MemToReg = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1; set_nop(); io_in = 8'h00; dmem_ack = 1'b0; dmem_rdata = 8'h00;
        step(); step();
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", dmem_req); end
        checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", dmem_we); end
        checks++; if (dmem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", dmem_addr); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", mem_err); end
        checks++; if (io_out !== 8'h00) begin errors++; $display("FAIL reset_io got %h exp 00", io_out); end
        checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL reset_wbrw got %0b exp 0", wb_regwrite); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", mem_stall); end
        rst = 1'b0;
    endtask

    task automatic test_alu_retire();
        MemToReg = 2'b00; ALU_res = 8'h3C; RegWrite = 1'b1; RegDistidx = 2'd2;
        #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL alu_stall_pre got %0b exp 0", mem_stall); end
        step();
        checks++; if (wb_data !== 8'h3C) begin errors++; $display("FAIL alu_wbdata got %h exp 3c", wb_data); end
        checks++; if (wb_idx !== 2'd2) begin errors++; $display("FAIL alu_wbidx got %0d exp 2", wb_idx); end
        checks++; if (wb_regwrite !== 1'b1) begin errors++; $display("FAIL alu_wbrw got %0b exp 1", wb_regwrite); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %0b exp 0", mem_stall); end
        set_nop();
        step();
    endtask

    task automatic test_load();
        int stall_cycles = 0;
        MemToReg = 2'b01; ALU_res = 8'h10; RegWrite = 1'b1; RegDistidx = 2'd1;
        #1;
        if (mem_stall) stall_cycles++;
        step();
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 8'h10) begin
            errors++; $display("FAIL load_port got req=%0b we=%0b addr=%h exp 1 0 10", dmem_req, dmem_we, dmem_addr); end
        checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL load_bubble got %0b exp 0", wb_regwrite); end
        if (mem_stall) stall_cycles++;
        step();
        if (mem_stall) stall_cycles++;
        step();
        dmem_ack = 1'b1; dmem_rdata = 8'hA5;
        #1;
        if (mem_stall) stall_cycles++;
        checks++; if (stall_cycles !== 3) begin errors++; $display("FAIL load_stall_cycles got %0d exp 3", stall_cycles); end
        step();
        dmem_ack = 1'b0; set_nop();
        checks++; if (wb_data !== 8'hA5 || wb_regwrite !== 1'b1 || wb_idx !== 2'd1) begin
            errors++; $display("FAIL load_wb got data=%h rw=%0b idx=%0d exp a5 1 1", wb_data, wb_regwrite, wb_idx); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL load_req_drop got %0b exp 0", dmem_req); end
        step();
    endtask

    task automatic test_call_push();
        int writes = 0;
        isCall = 1'b1; MemWrite = 1'b1; pc_plus1 = 8'h21; Rd2 = 8'h77; ALU_res = 8'hFE;
        step();
        checks++; if (dmem_we !== 1'b1 || dmem_wdata !== 8'h21 || dmem_addr !== 8'hFE) begin
            errors++; $display("FAIL call_port got we=%0b wdata=%h addr=%h exp 1 21 fe", dmem_we, dmem_wdata, dmem_addr); end
        dmem_ack = 1'b1;
        #1;
        if (dmem_req && dmem_we && dmem_ack) writes++;
        step();
        dmem_ack = 1'b0; set_nop();
        for (int i = 0; i < 3; i++) begin
            if (dmem_req && dmem_we) writes++;
            step();
        end
        checks++; if (writes !== 1) begin errors++; $display("FAIL call_writes got %0d exp 1", writes); end
        checks++; if (wb_regwrite !== 1'b0 || wb_data !== 8'h00) begin
            errors++; $display("FAIL call_wb got rw=%0b data=%h exp 0 00", wb_regwrite, wb_data); end
    endtask

    task automatic test_io();
        IO_Write = 1'b1; FW_value = 8'h5A;
        step();
        checks++; if (io_out !== 8'h5A) begin errors++; $display("FAIL io_out got %h exp 5a", io_out); end
        IO_Write = 1'b0; FW_value = 8'h99; MemToReg = 2'b10; io_in = 8'hC3; RegWrite = 1'b1;
        step();
        checks++; if (wb_data !== 8'hC3) begin errors++; $display("FAIL io_in_wb got %h exp c3", wb_data); end
        checks++; if (io_out !== 8'h5A) begin errors++; $display("FAIL io_hold got %h exp 5a", io_out); end
        MemToReg = 2'b11;
        step();
        checks++; if (wb_data !== 8'h99) begin errors++; $display("FAIL fwd_wb got %h exp 99", wb_data); end
        set_nop();
        step();
    endtask

    task automatic test_store_io();
        MemWrite = 1'b1; Rd2 = 8'h44; ALU_res = 8'h08; IO_Write = 1'b1; FW_value = 8'h66;
        RegWrite = 1'b1; RegDistidx = 2'd3;
        step();
        ALU_res = 8'hEE; Rd2 = 8'h00; FW_value = 8'h11;
        step();
        checks++; if (dmem_addr !== 8'h08 || dmem_wdata !== 8'h44) begin
            errors++; $display("FAIL store_hold got addr=%h wdata=%h exp 08 44", dmem_addr, dmem_wdata); end
        checks++; if (io_out !== 8'h5A) begin errors++; $display("FAIL store_io_early got %h exp 5a", io_out); end
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0; set_nop();
        checks++; if (io_out !== 8'h66) begin errors++; $display("FAIL store_io got %h exp 66", io_out); end
        checks++; if (wb_regwrite !== 1'b1 || wb_data !== 8'h00 || wb_idx !== 2'd3) begin
            errors++; $display("FAIL store_wb got rw=%0b data=%h idx=%0d exp 1 00 3", wb_regwrite, wb_data, wb_idx); end
        step();
    endtask

    task automatic test_back_to_back();
        MemToReg = 2'b01; ALU_res = 8'h20; RegWrite = 1'b1; RegDistidx = 2'd1;
        step();
        dmem_ack = 1'b1; dmem_rdata = 8'h11;
        step();
        dmem_ack = 1'b0; ALU_res = 8'h30; RegDistidx = 2'd2;
        checks++; if (wb_data !== 8'h11) begin errors++; $display("FAIL b2b_first got %h exp 11", wb_data); end
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall got %0b exp 1", mem_stall); end
        step();
        checks++; if (dmem_req !== 1'b1 || dmem_addr !== 8'h30) begin
            errors++; $display("FAIL b2b_second_req got req=%0b addr=%h exp 1 30", dmem_req, dmem_addr); end
        dmem_ack = 1'b1; dmem_rdata = 8'h22;
        step();
        dmem_ack = 1'b0; set_nop();
        checks++; if (wb_data !== 8'h22 || wb_idx !== 2'd2) begin
            errors++; $display("FAIL b2b_second got data=%h idx=%0d exp 22 2", wb_data, wb_idx); end
        step();
    endtask

    task automatic test_timeout();
        int busy = 0;
        bit done = 0;
        MemToReg = 2'b01; ALU_res = 8'h40; RegWrite = 1'b1; RegDistidx = 2'd1;
        step();
        for (int i = 0; i < 40 && !done; i++) begin
            if (dmem_req) begin
                busy++;
                if (mem_err !== 1'b0) begin
                    checks++; errors++; $display("FAIL timeout_err_early got %0b exp 0", mem_err);
                end
                step();
            end else begin
                done = 1;
            end
        end
        set_nop();
        checks++; if (!done) begin errors++; $display("FAIL timeout_bound got req=%0b exp 0", dmem_req); end
        checks++; if (busy !== 15) begin errors++; $display("FAIL timeout_cycles got %0d exp 15", busy); end
        checks++; if (mem_err !== 1'b1 || wb_regwrite !== 1'b0) begin
            errors++; $display("FAIL timeout_flags got err=%0b rw=%0b exp 1 0", mem_err, wb_regwrite); end
        dmem_ack = 1'b1; dmem_rdata = 8'hBB;
        step();
        dmem_ack = 1'b0;
        checks++; if (mem_err !== 1'b1 || dmem_req !== 1'b0 || wb_data !== 8'h00) begin
            errors++; $display("FAIL timeout_late_ack got err=%0b req=%0b data=%h exp 1 0 00", mem_err, dmem_req, wb_data); end
        step();
    endtask

    task automatic test_reset_mid_busy();
        IO_Write = 1'b1; FW_value = 8'h3F;
        step();
        MemToReg = 2'b01; ALU_res = 8'h55; IO_Write = 1'b0; RegWrite = 1'b1;
        step();
        step();
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %0b exp 1", dmem_req); end
        rst = 1'b1; set_nop();
        step();
        rst = 1'b0;
        checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || mem_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_ctl got req=%0b stall=%0b err=%0b exp 0 0 0", dmem_req, mem_stall, mem_err); end
        checks++; if (io_out !== 8'h00 || dmem_addr !== 8'h00 || wb_data !== 8'h00 || wb_regwrite !== 1'b0) begin
            errors++; $display("FAIL rstmid_outs got io=%h addr=%h data=%h rw=%0b exp 00 00 00 0", io_out, dmem_addr, wb_data, wb_regwrite); end
        step();
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rstmid_stay got %0b exp 0", dmem_req); end
    endtask

    initial begin
        test_reset();
        test_alu_retire();
        test_load();
        test_call_push();
        test_io();
        test_store_io();
        test_back_to_back();
        test_timeout();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
